// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - instruction and data bus bundle for core_sequencer
// Purpose: groups the fetch bus (ibus_*) and data bus (dbus_*) handshakes.
// Signals:
//   ibus_req  (master->slave) fetch request, held until ibus_ack
//   ibus_addr (master->slave) fetch address, equals the current pc
//   ibus_ack  (slave->master) fetch done, ibus_data valid this cycle
//   ibus_data (slave->master) fetched instruction word
//   dbus_req  (master->slave) data access request, held until dbus_ack
//   dbus_we   (master->slave) data access is a write
//   dbus_ack  (slave->master) data access done
interface core_sequencer_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_data;
    logic        dbus_req;
    logic        dbus_we;
    logic        dbus_ack;

    modport master (
        output ibus_req,
        output ibus_addr,
        input  ibus_ack,
        input  ibus_data,
        output dbus_req,
        output dbus_we,
        input  dbus_ack
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        output ibus_ack,
        output ibus_data,
        input  dbus_req,
        input  dbus_we,
        output dbus_ack
    );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle control FSM for the RISCuinho integer core
// Purpose: owns the pc, fetches over the instruction bus, latches the instruction for the
// decoder, steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and halts on traps.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   bus                 instruction/data bus bundle (master side)
//   o_instr             latched instruction for the decoder
//   i_dec_mem_r/_mem_w  decoder load/store flags
//   i_dec_reg_w         decoder: instruction writes rd
//   i_dec_system        decoder: ECALL/EBREAK
//   i_take_target       datapath: jump/branch taken (EXECUTE)
//   i_target            datapath: jump/branch target (EXECUTE)
//   o_reg_w_en          register-file write strobe
//   o_pc                current pc
//   o_retire            instruction retired pulse
//   o_instret           retired-instruction counter
//   o_trap              core halted on trap
//   o_trap_cause        00 none, 01 bus timeout, 10 ECALL/EBREAK, 11 misaligned target
//   o_state             FSM state for debug
module core_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BUS_TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    core_sequencer_if.master     bus,
    output logic [31:0]          o_instr,
    input  logic                 i_dec_mem_r,
    input  logic                 i_dec_mem_w,
    input  logic                 i_dec_reg_w,
    input  logic                 i_dec_system,
    input  logic                 i_take_target,
    input  logic [31:0]          i_target,
    output logic                 o_reg_w_en,
    output logic [31:0]          o_pc,
    output logic                 o_retire,
    output logic [31:0]          o_instret,
    output logic                 o_trap,
    output logic [1:0]           o_trap_cause,
    output logic [2:0]           o_state
);

    localparam int          WAIT_W  = $clog2(BUS_TIMEOUT + 1);
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_trap_cause;
    logic [1:0]          w_trap_cause_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                w_wait_clr;
    logic                w_wait_inc;
    logic                w_timeout_hit;
    logic [31:0]         r_pc;
    logic [31:0]         r_next_pc;
    logic [31:0]         r_instr;
    logic [31:0]         r_instret;
    logic                r_ibus_req;
    logic                r_dbus_req;
    logic                r_dbus_we;
    logic                r_reg_w_en;
    logic                r_retire;
    logic [31:0]         w_target_aligned;
    logic [31:0]         w_next_pc_calc;
    logic                w_target_misaligned;

    // Bit 0 of a jump target is dropped; bit 1 set means a halfword-aligned target we cannot run.
    assign w_target_aligned    = i_target & ~32'd1;
    assign w_target_misaligned = i_take_target & i_target[1];
    assign w_next_pc_calc      = i_take_target ? w_target_aligned : r_pc + 32'd4;
    assign w_timeout_hit       = (r_wait_cnt == WAIT_W'(BUS_TIMEOUT - 1));

    always_comb begin
        w_state_nxt      = r_state;
        w_trap_cause_nxt = r_trap_cause;
        w_wait_inc       = 1'b0;
        case (r_state)
            S_FETCH: begin
                // The ack is only meaningful while our request is actually on the bus.
                if (r_ibus_req) begin
                    if (bus.ibus_ack) begin
                        w_state_nxt = S_DECODE;
                    end else if (w_timeout_hit) begin
                        w_state_nxt      = S_HALT;
                        w_trap_cause_nxt = 2'b01;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (i_dec_system) begin
                    w_state_nxt      = S_HALT;
                    w_trap_cause_nxt = 2'b10;
                end else begin
                    w_state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (w_target_misaligned) begin
                    w_state_nxt      = S_HALT;
                    w_trap_cause_nxt = 2'b11;
                end else if (i_dec_mem_r | i_dec_mem_w) begin
                    w_state_nxt = S_MEMORY;
                end else begin
                    w_state_nxt = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (r_dbus_req) begin
                    if (bus.dbus_ack) begin
                        w_state_nxt = S_WRITEBACK;
                    end else if (w_timeout_hit) begin
                        w_state_nxt      = S_HALT;
                        w_trap_cause_nxt = 2'b01;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                // Corrupted state encoding is treated like a bus fault.
                w_state_nxt      = S_HALT;
                w_trap_cause_nxt = 2'b01;
            end
        endcase
    end

    // The wait counter restarts whenever a new bus phase begins.
    assign w_wait_clr = ((w_state_nxt == S_FETCH)  && (r_state != S_FETCH)) ||
                        ((w_state_nxt == S_MEMORY) && (r_state != S_MEMORY));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Requests and strobes are registered from the next state so that they are glitch-free
    // and drop to zero in the cycle right after a reset edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ibus_req <= 1'b0;
            r_dbus_req <= 1'b0;
            r_dbus_we  <= 1'b0;
            r_reg_w_en <= 1'b0;
            r_retire   <= 1'b0;
        end else begin
            r_ibus_req <= (w_state_nxt == S_FETCH);
            r_dbus_req <= (w_state_nxt == S_MEMORY);
            r_dbus_we  <= (w_state_nxt == S_MEMORY) & i_dec_mem_w;
            r_reg_w_en <= (w_state_nxt == S_WRITEBACK) & i_dec_reg_w;
            r_retire   <= (w_state_nxt == S_WRITEBACK);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= RESET_PC;
            r_next_pc    <= RESET_PC;
            r_instr      <= NOP_INS;
            r_instret    <= 32'd0;
            r_trap_cause <= 2'b00;
            r_wait_cnt   <= '0;
        end else begin
            r_trap_cause <= w_trap_cause_nxt;
            if ((r_state == S_FETCH) && r_ibus_req && bus.ibus_ack) begin
                r_instr <= bus.ibus_data;
            end
            if (r_state == S_EXECUTE) begin
                r_next_pc <= w_next_pc_calc;
            end
            if (r_state == S_WRITEBACK) begin
                r_pc      <= r_next_pc;
                r_instret <= r_instret + 32'd1;
            end
            if (w_wait_clr) begin
                r_wait_cnt <= '0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.ibus_req  = r_ibus_req;
    assign bus.ibus_addr = r_pc;
    assign bus.dbus_req  = r_dbus_req;
    assign bus.dbus_we   = r_dbus_we;

    assign o_instr      = r_instr;
    assign o_reg_w_en   = r_reg_w_en;
    assign o_pc         = r_pc;
    assign o_retire     = r_retire;
    assign o_instret    = r_instret;
    assign o_trap       = (r_state == S_HALT);
    assign o_trap_cause = r_trap_cause;
    assign o_state      = r_state;

endmodule
